// File: rtl/free_list_mp.sv
// Multi-port bitmap free list for the rename stage: ALLOC_W all-or-nothing
// allocate lanes, FREE_W release lanes, registered count and sticky double-free flag.
module free_list_mp #(
  parameter int P_REG_SIZE = 128,
  parameter int P_WIDTH    = $clog2(P_REG_SIZE),
  parameter int ARCH_REGS  = 32,
  parameter int ALLOC_W    = 2,
  parameter int FREE_W     = 2,
  parameter int CNT_W      = $clog2(P_REG_SIZE + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [P_REG_SIZE-1:0]      backup_free_list,
  input  logic [ALLOC_W-1:0]         alloc_req,
  output logic                       alloc_gnt,
  output logic [ALLOC_W*P_WIDTH-1:0] alloc_pd,
  input  logic [FREE_W-1:0]          free_valid,
  input  logic [FREE_W*P_WIDTH-1:0]  free_pd,
  output logic [CNT_W-1:0]           free_count,
  output logic                       can_alloc_all,
  output logic                       double_free_err
);

  localparam logic [P_REG_SIZE-1:0] RST_MAP = {P_REG_SIZE{1'b1}} << ARCH_REGS;

  logic [P_REG_SIZE-1:0] bitmap;
  logic [P_REG_SIZE-1:0] avail;
  logic [P_REG_SIZE-1:0] take;
  logic [P_REG_SIZE-1:0] seen;
  logic [P_REG_SIZE-1:0] bitmap_nxt;
  logic [CNT_W-1:0]      nreq;
  logic [P_WIDTH-1:0]    rel_pd;
  logic                  found;
  logic                  dbl;

  function automatic logic [CNT_W-1:0] popcnt(input logic [P_REG_SIZE-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < P_REG_SIZE; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Lane-ordered pick: each requesting lane takes the lowest bit left over by earlier lanes
  always_comb begin
    avail    = bitmap;
    take     = '0;
    alloc_pd = '0;
    nreq     = '0;
    found    = 1'b0;
    for (int i = 0; i < ALLOC_W; i++) begin
      nreq  = nreq + CNT_W'(alloc_req[i]);
      found = 1'b0;
      if (alloc_req[i]) begin
        for (int j = 0; j < P_REG_SIZE; j++) begin
          if (!found && avail[j]) begin
            found                         = 1'b1;
            avail[j]                      = 1'b0;
            take[j]                       = 1'b1;
            alloc_pd[i*P_WIDTH +: P_WIDTH] = P_WIDTH'(j);
          end
        end
      end
    end
    alloc_gnt = (nreq != '0) && (nreq <= free_count) && !flush;
  end

  // Releases apply after the allocation clear, so a same-cycle collision leaves the bit free
  always_comb begin
    bitmap_nxt = alloc_gnt ? (bitmap & ~take) : bitmap;
    seen       = '0;
    dbl        = 1'b0;
    rel_pd     = '0;
    for (int i = 0; i < FREE_W; i++) begin
      rel_pd = free_pd[i*P_WIDTH +: P_WIDTH];
      if (free_valid[i] && (rel_pd != '0)) begin
        if (bitmap[rel_pd] || seen[rel_pd]) dbl = 1'b1;
        seen[rel_pd]       = 1'b1;
        bitmap_nxt[rel_pd] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bitmap          <= RST_MAP;
      free_count      <= CNT_W'(P_REG_SIZE - ARCH_REGS);
      double_free_err <= 1'b0;
    end else if (flush) begin
      bitmap     <= backup_free_list;
      free_count <= popcnt(backup_free_list);
    end else begin
      bitmap     <= bitmap_nxt;
      free_count <= popcnt(bitmap_nxt);
      if (dbl) double_free_err <= 1'b1;
    end
  end

  assign can_alloc_all = (free_count >= CNT_W'(ALLOC_W));

endmodule

// File: tb/tb_free_list_mp.sv
// Bench for free_list_mp: directed scenarios plus randomized traffic against a
// queue-based reference model of the free pool.
module tb_free_list_mp;

  localparam int P  = 128;
  localparam int PW = 7;
  localparam int AR = 32;
  localparam int AW = 2;
  localparam int FW = 2;
  localparam int CW = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           flush = 1'b0;
  logic [P-1:0]   backup_free_list = '0;
  logic [AW-1:0]  alloc_req = '0;
  logic           alloc_gnt;
  logic [AW*PW-1:0] alloc_pd;
  logic [FW-1:0]  free_valid = '0;
  logic [FW*PW-1:0] free_pd = '0;
  logic [CW-1:0]  free_count;
  logic           can_alloc_all;
  logic           double_free_err;

  free_list_mp dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .backup_free_list(backup_free_list),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_pd(alloc_pd),
    .free_valid(free_valid), .free_pd(free_pd), .free_count(free_count),
    .can_alloc_all(can_alloc_all), .double_free_err(double_free_err)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // reference model: set of free registers as a plain bit vector
  logic [P-1:0]     mfree = '0;
  bit               merr = 1'b0;
  bit               minit = 1'b0;
  logic             last_gnt;
  logic [AW*PW-1:0] last_pd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int mcount(input logic [P-1:0] v);
    int c = 0;
    for (int i = 0; i < P; i++) if (v[i]) c++;
    return c;
  endfunction

  task automatic cycle(input bit r, input bit f, input logic [P-1:0] bk,
                       input logic [AW-1:0] rq, input logic [FW-1:0] fv,
                       input logic [FW*PW-1:0] fp);
    int q[$];
    int epd[AW];
    int nr;
    bit egnt;
    logic [P-1:0] old;
    logic [P-1:0] rel;
    int pd;
    @(negedge clk);
    rst_n = r; flush = f; backup_free_list = bk;
    alloc_req = rq; free_valid = fv; free_pd = fp;
    #1;
    last_gnt = alloc_gnt;
    last_pd  = alloc_pd;
    nr = 0;
    for (int i = 0; i < AW; i++) if (rq[i]) nr++;
    for (int i = 0; i < P; i++) if (mfree[i]) q.push_back(i);
    egnt = minit && !f && nr > 0 && nr <= q.size();
    for (int i = 0; i < AW; i++) epd[i] = (egnt && rq[i]) ? q.pop_front() : 0;
    if (minit) begin
      check("free_count", 32'(free_count), 32'(mcount(mfree)));
      check("can_alloc_all", 32'(can_alloc_all), 32'(mcount(mfree) >= AW));
      check("double_free_err", 32'(double_free_err), 32'(merr));
      if (r) begin
        check("alloc_gnt", 32'(alloc_gnt), 32'(egnt));
        if (egnt)
          for (int i = 0; i < AW; i++)
            check($sformatf("alloc_pd%0d", i), 32'(alloc_pd[i*PW +: PW]), 32'(epd[i]));
      end
    end
    if (!r) begin
      for (int i = 0; i < P; i++) mfree[i] = (i >= AR);
      merr  = 1'b0;
      minit = 1'b1;
    end else if (minit && f) begin
      mfree = bk;
    end else if (minit) begin
      old = mfree;
      rel = '0;
      if (egnt) for (int i = 0; i < AW; i++) if (rq[i]) mfree[epd[i]] = 1'b0;
      for (int l = 0; l < FW; l++) begin
        pd = int'(fp[l*PW +: PW]);
        if (fv[l] && pd != 0) begin
          if (old[pd] || rel[pd]) merr = 1'b1;
          rel[pd]   = 1'b1;
          mfree[pd] = 1'b1;
        end
      end
    end
    @(posedge clk);
  endtask

  task automatic idle(input logic [AW-1:0] rq);
    cycle(1'b1, 1'b0, '0, rq, '0, '0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, '0, 2'b11, 2'b11, {7'd60, 7'd3});
  endtask

  initial begin
    logic [P-1:0] bk;
    logic [AW-1:0] rq;
    logic [FW-1:0] fv;
    logic [FW*PW-1:0] fp;
    int idx;

    // allocate two lanes after reset
    do_reset();
    #1 check("rst_count", 32'(free_count), 32'd96);
    check("rst_err", 32'(double_free_err), 32'd0);
    idle(2'b11);
    check("tp1_gnt", 32'(last_gnt), 32'd1);
    check("tp1_pd0", 32'(last_pd[6:0]), 32'd32);
    check("tp1_pd1", 32'(last_pd[13:7]), 32'd33);
    idle(2'b11);
    check("tp1b_pd0", 32'(last_pd[6:0]), 32'd34);
    check("tp1b_pd1", 32'(last_pd[13:7]), 32'd35);

    // lane1-only request
    do_reset();
    idle(2'b10);
    check("tp2_pd0", 32'(last_pd[6:0]), 32'd0);
    check("tp2_pd1", 32'(last_pd[13:7]), 32'd32);
    #1 check("tp2_count", 32'(free_count), 32'd95);

    // drain to one, then all-or-nothing refusal and last register
    do_reset();
    idle(2'b01);
    for (int i = 0; i < 47; i++) idle(2'b11);
    idle(2'b11);
    check("drain_gnt", 32'(last_gnt), 32'd0);
    #1 check("drain_count1", 32'(free_count), 32'd1);
    idle(2'b01);
    check("drain_pd", 32'(last_pd[6:0]), 32'd127);
    idle(2'b00);
    check("empty_count", 32'(free_count), 32'd0);
    check("empty_can", 32'(can_alloc_all), 32'd0);
    idle(2'b01);
    check("empty_gnt", 32'(last_gnt), 32'd0);

    // release 5 and 40 while allocating two
    do_reset();
    for (int i = 0; i < 5; i++) idle(2'b11);
    cycle(1'b1, 1'b0, '0, 2'b11, 2'b11, {7'd40, 7'd5});
    check("mix_pd0", 32'(last_pd[6:0]), 32'd42);
    check("mix_pd1", 32'(last_pd[13:7]), 32'd43);
    #1 check("mix_count", 32'(free_count), 32'd86);
    idle(2'b11);
    check("mix_next_pd0", 32'(last_pd[6:0]), 32'd5);
    check("mix_next_pd1", 32'(last_pd[13:7]), 32'd40);

    // p0 release ignored, then double frees of 50
    do_reset();
    for (int i = 0; i < 10; i++) idle(2'b11);
    cycle(1'b1, 1'b0, '0, 2'b00, 2'b01, {7'd0, 7'd0});
    #1 check("p0_count", 32'(free_count), 32'd76);
    check("p0_err", 32'(double_free_err), 32'd0);
    cycle(1'b1, 1'b0, '0, 2'b00, 2'b11, {7'd50, 7'd50});
    #1 check("dup_count", 32'(free_count), 32'd77);
    check("dup_err", 32'(double_free_err), 32'd1);
    cycle(1'b1, 1'b0, '0, 2'b00, 2'b01, {7'd0, 7'd50});
    #1 check("refree_count", 32'(free_count), 32'd77);
    check("refree_err", 32'(double_free_err), 32'd1);

    // flush restore, then reset clears the error
    bk = {P{1'b1}} << 32;
    bk[5] = 1'b1;
    cycle(1'b1, 1'b1, bk, 2'b11, 2'b01, {7'd0, 7'd20});
    check("flush_gnt", 32'(last_gnt), 32'd0);
    #1 check("flush_count", 32'(free_count), 32'd97);
    check("flush_err", 32'(double_free_err), 32'd1);
    idle(2'b01);
    check("flush_pd", 32'(last_pd[6:0]), 32'd5);
    do_reset();
    #1 check("rst2_count", 32'(free_count), 32'd96);
    check("rst2_err", 32'(double_free_err), 32'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rq = AW'($urandom_range(3));
      fv = '0;
      fp = '0;
      for (int l = 0; l < FW; l++) begin
        if ($urandom_range(99) < 40) begin
          fv[l] = 1'b1;
          idx = $urandom_range(P - 1);
          for (int t = 0; t < 8 && mfree[idx]; t++) idx = $urandom_range(P - 1);
          if ($urandom_range(99) < 3) idx = 0;
          fp[l*PW +: PW] = PW'(idx);
        end
      end
      bk = {$urandom, $urandom, $urandom, $urandom};
      cycle($urandom_range(299) != 0, $urandom_range(59) == 0, bk, rq, fv, fp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/free_list_mp.md
Name: free_list_mp

Overview:
- Multi-port physical-register free list for the rename stage of a superscalar OoO core.
- Bitmap-based, like the current single-port list.
- Adds ALLOC_W allocate lanes per cycle with all-or-nothing grant, FREE_W release lanes per cycle from commit, a registered free count, p0 protection and sticky double-free detection.
- Flush restores the bitmap from the RRAT backup.

Parameters:
- P_REG_SIZE, 128, number of physical registers.
- P_WIDTH, $clog2(P_REG_SIZE), physical index width.
- ARCH_REGS, 32, registers 0..ARCH_REGS-1 taken at reset.
- ALLOC_W, 2, allocate lanes (1..4).
- FREE_W, 2, release lanes (1..4).
- CNT_W, $clog2(P_REG_SIZE+1), free_count width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  mispredict recovery; restore from backup_free_list.
- backup_free_list  in  P_REG_SIZE  RRAT free bitmap (1 = free).
- alloc_req  in  ALLOC_W  per-lane allocate request.
- alloc_gnt  out  1  all requested lanes granted this cycle.
- alloc_pd  out  ALLOC_W*P_WIDTH  per-lane allocated index; lane i at [i*P_WIDTH +: P_WIDTH].
- free_valid  in  FREE_W  per-lane release valid.
- free_pd  in  FREE_W*P_WIDTH  per-lane released index.
- free_count  out  CNT_W  registered number of free registers.
- can_alloc_all  out  1  free_count >= ALLOC_W.
- double_free_err  out  1  sticky: a release targeted an already-free register.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset (rst_n=0 at posedge):
  - bitmap[0..ARCH_REGS-1]=0, rest 1.
  - free_count=P_REG_SIZE-ARCH_REGS (96).
  - double_free_err=0.
  - Any in-flight request that cycle is discarded.
- Allocation is combinational from current bitmap state; register state updates at next posedge.
  - Requested lanes are ordered by ascending lane index. The k-th requested lane receives the k-th lowest-index free register.
  - alloc_pd of non-requested lanes = 0.
  - alloc_gnt=1 iff popcount(alloc_req) <= free_count, popcount(alloc_req)>0, and flush=0.
  - If alloc_gnt=0, no bit is cleared: all-or-nothing, state unchanged by the alloc side. alloc_pd values are then don't-care.
  - On grant, granted bits are cleared at the posedge.
- Release:
  - Each free_valid lane sets bitmap[free_pd] at the posedge.
  - Releases are visible to allocation the following cycle only; no same-cycle bypass.
  - free_pd==0 is ignored (p0 hardwired to x0).
  - If the target bit is already 1, or two lanes name the same index in one cycle, set double_free_err. The bit stays 1 and the count increments once only.
  - double_free_err clears only on reset.
- Simultaneous alloc and release of different registers: both apply.
  - A release cannot target a register allocated in the same cycle, since it was not free. If this happens anyway, treat it as a release: final bit=1, and flag double_free_err.
- free_count next = free_count − granted allocs + effective (deduplicated, non-p0, previously-0) releases. Equivalently, the popcount of the next bitmap. It never exceeds P_REG_SIZE and never underflows.
- Flush (priority over everything but reset):
  - bitmap <= backup_free_list.
  - free_count <= popcount(backup_free_list).
  - alloc and release inputs are ignored that cycle.
  - alloc_gnt=0 that cycle.
  - double_free_err is unchanged.
- can_alloc_all is derived from registered free_count.
- Empty: free_count=0 → alloc_gnt=0 for any nonzero request.
- No FSM beyond the state registers (bitmap, count, error flag); all outputs other than alloc_gnt/alloc_pd are registered.

Test Plan:
- Reset then alloc_req=2'b11 → alloc_gnt=1, alloc_pd lane0=32, lane1=33; next cycle free_count=94, next grant gives 34,35.
- alloc_req=2'b10 only after reset → lane1 gets 32, lane0 pd=0; free_count 95.
- Drain until free_count=1, request 2'b11 → alloc_gnt=0, free_count stays 1; request 2'b01 → pd=127, then free_count=0, can_alloc_all=0.
- Same cycle: free lanes release 5 and 40 (40 allocated earlier) while allocating 2 → both apply; count net 0; 40 not returned until next cycle.
- Release 50 twice in one cycle, then release 50 again later (already free) → count +1 once, double_free_err=1 and stays 1; release p0 → no count change, no error.
- Allocate several, assert flush with backup = regs 32..127 free plus reg 5 free → free_count=97, alloc_gnt=0 that cycle; next cycle alloc lane0=5. Drop rst_n mid-run → free_count=96, double_free_err=0.
